// File: rtl/lightbike_pkg.sv
// Shared constants for the lightbike keyboard path: scan codes, turn encoding,
// prefix FSM states and the key-to-held-bit map.
package lightbike_pkg;

  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_D     = 8'h23;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;

  localparam logic [1:0] TURN_NONE  = 2'b00;
  localparam logic [1:0] TURN_LEFT  = 2'b01;
  localparam logic [1:0] TURN_RIGHT = 2'b10;

  // Bit positions in the held vector {space, p2R, p2L, p1D, p1A}
  localparam int unsigned HeldP1L   = 0;
  localparam int unsigned HeldP1R   = 1;
  localparam int unsigned HeldP2L   = 2;
  localparam int unsigned HeldP2R   = 3;
  localparam int unsigned HeldSpace = 4;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} ps2_state_e;

  // Keyboard status/protocol bytes that never carry key data
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE: is_ignored = 1'b1;
      default:                           is_ignored = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] key_onehot(input logic ext, input logic [7:0] code);
    key_onehot = 5'b00000;
    if (!ext) begin
      if (code == KC_A)     key_onehot[HeldP1L]   = 1'b1;
      if (code == KC_D)     key_onehot[HeldP1R]   = 1'b1;
      if (code == KC_SPACE) key_onehot[HeldSpace] = 1'b1;
    end else begin
      if (code == KC_LEFT)  key_onehot[HeldP2L]   = 1'b1;
      if (code == KC_RIGHT) key_onehot[HeldP2R]   = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Tracks E0/F0 prefixes and emits a one-cycle make/break strobe with the data
// byte; a stale prefix is abandoned after TIMEOUT_CYCLES without a follow-up.
module ps2_prefix_fsm
  import lightbike_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned TO_W           = 22
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       key_valid,
  output logic       key_make,
  output logic       key_ext,
  output logic [7:0] key_code
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_code = scan_code;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_valid = 1'b0;
    key_make  = 1'b0;
    key_ext   = 1'b0;
    if (scan_valid) begin
      cnt_d = '0;
      if (is_ignored(scan_code)) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (scan_code == PFX_EXT) begin
              state_d = StExt;
            end else if (scan_code == PFX_BRK) begin
              state_d = StBrk;
            end else begin
              key_valid = 1'b1;
              key_make  = 1'b1;
            end
          end
          StExt: begin
            if (scan_code == PFX_BRK) begin
              state_d = StExtBrk;
            end else begin
              key_valid = 1'b1;
              key_make  = 1'b1;
              key_ext   = 1'b1;
              state_d   = StIdle;
            end
          end
          StBrk: begin
            key_valid = 1'b1;
            state_d   = StIdle;
          end
          StExtBrk: begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            state_d   = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle) begin
      if (cnt_q == CntLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: rtl/ps2_turn_decoder.sv
// Turns decoded PS/2 make/break events into latched per-player turn requests,
// a start strobe and held-key flags, suppressing typematic repeats.
module ps2_turn_decoder
  import lightbike_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned TO_W           = 22
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       tick,
  output logic [1:0] p1_turn,
  output logic [1:0] p2_turn,
  output logic       start_pulse,
  output logic [7:0] last_code,
  output logic [4:0] held
);

  logic       key_valid, key_make, key_ext;
  logic [7:0] key_code;
  logic [4:0] key_oh, press;

  logic [1:0] p1_q, p1_d, p2_q, p2_d;
  logic       start_q, start_d;
  logic [7:0] last_q, last_d;
  logic [4:0] held_q, held_d;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_prefix_fsm (
    .board_clk (board_clk),
    .reset     (reset),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .key_valid (key_valid),
    .key_make  (key_make),
    .key_ext   (key_ext),
    .key_code  (key_code)
  );

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      p1_q    <= TURN_NONE;
      p2_q    <= TURN_NONE;
      start_q <= 1'b0;
      last_q  <= 8'h00;
      held_q  <= 5'b00000;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      start_q <= start_d;
      last_q  <= last_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    key_oh  = key_valid ? key_onehot(key_ext, key_code) : 5'b00000;
    // Only a make of a key not already down counts as a fresh press
    press   = (key_valid && key_make) ? (key_oh & ~held_q) : 5'b00000;
    held_d  = held_q;
    if (key_valid) held_d = key_make ? (held_q | key_oh) : (held_q & ~key_oh);
    last_d  = scan_valid ? scan_code : last_q;
    start_d = press[HeldSpace];

    p1_d = tick ? TURN_NONE : p1_q;
    if (press[HeldP1L]) p1_d = TURN_LEFT;
    if (press[HeldP1R]) p1_d = TURN_RIGHT;
    p2_d = tick ? TURN_NONE : p2_q;
    if (press[HeldP2L]) p2_d = TURN_LEFT;
    if (press[HeldP2R]) p2_d = TURN_RIGHT;
  end

  assign p1_turn     = p1_q;
  assign p2_turn     = p2_q;
  assign start_pulse = start_q;
  assign last_code   = last_q;
  assign held        = held_q;

endmodule

// File: tb/tb_ps2_turn_decoder.sv
// Directed bench for ps2_turn_decoder with a short prefix timeout.
module tb_ps2_turn_decoder;

  localparam int unsigned TO = 16;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code  = 8'h00;
  logic       tick       = 1'b0;
  logic [1:0] p1_turn, p2_turn;
  logic       start_pulse;
  logic [7:0] last_code;
  logic [4:0] held;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_turn_decoder #(
    .TIMEOUT_CYCLES(TO),
    .TO_W          (5)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .tick       (tick),
    .p1_turn    (p1_turn),
    .p2_turn    (p2_turn),
    .start_pulse(start_pulse),
    .last_code  (last_code),
    .held       (held)
  );

  always #5 board_clk = ~board_clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic send_byte(input logic [7:0] code);
    @(negedge board_clk);
    scan_valid = 1'b1;
    scan_code  = code;
    @(negedge board_clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic pulse_tick();
    @(negedge board_clk);
    tick = 1'b1;
    @(negedge board_clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge board_clk);
    reset = 1'b1;
    @(negedge board_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({p1_turn, p2_turn, start_pulse, last_code, held} !== 18'h0) begin
      $display("FAIL reset_outputs: got %h want 0",
               {p1_turn, p2_turn, start_pulse, last_code, held});
      n_fail++;
    end
  endtask

  task automatic test_p1_left_tick();
    do_reset();
    send_byte(8'h1C);
    n_cmp++;
    if (p1_turn !== 2'b01 || held !== 5'b00001) begin
      $display("FAIL p1_left_make: p1=%b held=%b want 01/00001", p1_turn, held);
      n_fail++;
    end
    pulse_tick();
    n_cmp++;
    if (p1_turn !== 2'b00) begin
      $display("FAIL p1_tick_clear: p1=%b want 00", p1_turn);
      n_fail++;
    end
  endtask

  task automatic test_typematic();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    n_cmp++;
    if (p1_turn !== 2'b01 || last_code !== 8'h1C) begin
      $display("FAIL repeat_latch: p1=%b last=%h want 01/1c", p1_turn, last_code);
      n_fail++;
    end
    pulse_tick();
    send_byte(8'h1C);
    n_cmp++;
    if (p1_turn !== 2'b00) begin
      $display("FAIL repeat_suppressed: p1=%b want 00", p1_turn);
      n_fail++;
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_cmp++;
    if (held !== 5'b00000 || p1_turn !== 2'b00) begin
      $display("FAIL p1_break: held=%b p1=%b want 00000/00", held, p1_turn);
      n_fail++;
    end
    send_byte(8'h1C);
    n_cmp++;
    if (p1_turn !== 2'b01) begin
      $display("FAIL remake_after_break: p1=%b want 01", p1_turn);
      n_fail++;
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h74);
    n_cmp++;
    if (p2_turn !== 2'b10 || held !== 5'b01000) begin
      $display("FAIL p2_right_make: p2=%b held=%b want 10/01000", p2_turn, held);
      n_fail++;
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    n_cmp++;
    if (p2_turn !== 2'b10 || held !== 5'b00000 || last_code !== 8'h74) begin
      $display("FAIL p2_ext_break: p2=%b held=%b last=%h want 10/00000/74",
               p2_turn, held, last_code);
      n_fail++;
    end
  endtask

  task automatic test_make_with_tick();
    do_reset();
    send_byte(8'h1C);
    @(negedge board_clk);
    scan_valid = 1'b1;
    scan_code  = 8'h23;
    tick       = 1'b1;
    #1;
    n_cmp++;
    if (p1_turn !== 2'b01) begin
      $display("FAIL tick_cycle_value: p1=%b want 01", p1_turn);
      n_fail++;
    end
    @(negedge board_clk);
    scan_valid = 1'b0;
    tick       = 1'b0;
    n_cmp++;
    if (p1_turn !== 2'b10 || held !== 5'b00011) begin
      $display("FAIL make_beats_tick: p1=%b held=%b want 10/00011", p1_turn, held);
      n_fail++;
    end
    pulse_tick();
    n_cmp++;
    if (p1_turn !== 2'b00) begin
      $display("FAIL second_tick_clear: p1=%b want 00", p1_turn);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    // Follow-up just inside the window is still extended
    do_reset();
    send_byte(8'hE0);
    idle(TO - 2);
    send_byte(8'h6B);
    n_cmp++;
    if (p2_turn !== 2'b01 || held !== 5'b00100) begin
      $display("FAIL ext_within_window: p2=%b held=%b want 01/00100", p2_turn, held);
      n_fail++;
    end
    do_reset();
    send_byte(8'hE0);
    idle(TO);
    send_byte(8'h6B);
    n_cmp++;
    if (p2_turn !== 2'b00 || held !== 5'b00000 || last_code !== 8'h6B) begin
      $display("FAIL ext_timed_out: p2=%b held=%b last=%h want 00/00000/6b",
               p2_turn, held, last_code);
      n_fail++;
    end
  endtask

  task automatic test_ignored_bytes();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'hFA);
    send_byte(8'h74);
    n_cmp++;
    if (p2_turn !== 2'b00 || last_code !== 8'h74) begin
      $display("FAIL ignored_resets_prefix: p2=%b last=%h want 00/74", p2_turn, last_code);
      n_fail++;
    end
  endtask

  task automatic test_start_and_reset();
    do_reset();
    send_byte(8'h29);
    n_cmp++;
    if (start_pulse !== 1'b1 || held !== 5'b10000) begin
      $display("FAIL start_high: start=%b held=%b want 1/10000", start_pulse, held);
      n_fail++;
    end
    @(negedge board_clk);
    n_cmp++;
    if (start_pulse !== 1'b0) begin
      $display("FAIL start_one_cycle: start=%b want 0", start_pulse);
      n_fail++;
    end
    send_byte(8'h1C);
    send_byte(8'hE0);
    @(negedge board_clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({p1_turn, p2_turn, start_pulse, last_code, held} !== 18'h0) begin
      $display("FAIL async_reset_clear: got %h want 0",
               {p1_turn, p2_turn, start_pulse, last_code, held});
      n_fail++;
    end
    @(negedge board_clk);
    reset = 1'b0;
    send_byte(8'h74);
    n_cmp++;
    if (p2_turn !== 2'b00 || held !== 5'b00000 || last_code !== 8'h74) begin
      $display("FAIL prefix_dropped_by_reset: p2=%b held=%b last=%h want 00/00000/74",
               p2_turn, held, last_code);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_p1_left_tick();
    test_typematic();
    test_extended();
    test_make_with_tick();
    test_timeout();
    test_ignored_bytes();
    test_start_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
